// File: rtl/op_pkg.sv
// Operation encoding shared by the button front end and the cursor-move stage.
// Bit indices double as one-hot positions on the operation bus.
package op_pkg;

    localparam int OP_W       = 5;
    localparam int OP_CONFIRM = 0;
    localparam int OP_LEFT    = 1;
    localparam int OP_RIGHT   = 2;
    localparam int OP_UP      = 3;
    localparam int OP_DOWN    = 4;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // Keeps only the lowest set bit: confirm > left > right > up > down.
    function automatic logic [OP_W-1:0] op_first(input logic [OP_W-1:0] req);
        logic [OP_W-1:0] res;
        res = '0;
        for (int i = OP_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for one button.
// Latency: level follows a clean raw change DEBOUNCE_CYCLES+1 edges after the first sampling edge; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= ~r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/btn_op_gen.sv
// Debounced five-button front end producing one-hot single-cycle operation pulses.
// Latency: DEBOUNCE_CYCLES+3 edges from raw press to pulse; events arriving while busy are dropped, never queued.
// Optional auto-repeat of direction buttons is built when BTN_AUTO_REPEAT_EN is defined.
module btn_op_gen
    import op_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] btn_raw,
    input  logic            busy,
    output logic [OP_W-1:0] operation,
    output logic [OP_W-1:0] btn_level
);

    logic [OP_W-1:0] w_level;
    logic [OP_W-1:0] r_level_d;
    logic [OP_W-1:0] r_press;
    logic [OP_W-1:0] w_press_win;
    logic [OP_W-1:0] w_op_next;
    logic [OP_W-1:0] r_op;

    for (genvar g = 0; g < OP_W; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (btn_raw[g]),
            .o_level(w_level[g])
        );
    end

    // Rising edges of the debounced levels, registered once to give a clean event vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= '0;
            r_press   <= '0;
        end else begin
            r_level_d <= w_level;
            r_press   <= w_level & ~r_level_d;
        end
    end

    assign w_press_win = op_first(r_press);

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    rpt_state_t      r_state;
    rpt_state_t      w_state_nxt;
    logic [OP_W-1:0] r_rpt_bit;
    logic [OP_W-1:0] w_rpt_bit_nxt;
    logic [31:0]     r_rpt_cnt;
    logic [31:0]     w_rpt_cnt_nxt;
    logic            w_rpt_fire;
    logic            w_tracked_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RPT_IDLE;
            r_rpt_bit <= '0;
            r_rpt_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_bit <= w_rpt_bit_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rpt_bit_nxt  = r_rpt_bit;
        w_rpt_cnt_nxt  = r_rpt_cnt + 32'd1;
        w_rpt_fire     = 1'b0;
        w_op_next      = '0;
        w_tracked_held = |(r_rpt_bit & w_level);

        case (r_state)
            RPT_DELAY:  w_rpt_fire = w_tracked_held && (r_rpt_cnt == DELAY_LAST);
            RPT_REPEAT: w_rpt_fire = w_tracked_held && (r_rpt_cnt == PERIOD_LAST);
            default:    w_rpt_fire = 1'b0;
        endcase

        // A fresh press always beats a pending repeat in the same cycle.
        if (busy) begin
            w_state_nxt   = RPT_IDLE;
            w_rpt_bit_nxt = '0;
            w_rpt_cnt_nxt = '0;
        end else if (|w_press_win) begin
            w_op_next     = w_press_win;
            w_rpt_cnt_nxt = '0;
            if (w_press_win[OP_CONFIRM]) begin
                w_state_nxt   = RPT_IDLE;
                w_rpt_bit_nxt = '0;
            end else begin
                w_state_nxt   = RPT_DELAY;
                w_rpt_bit_nxt = w_press_win;
            end
        end else if (r_state != RPT_IDLE && !w_tracked_held) begin
            w_state_nxt   = RPT_IDLE;
            w_rpt_bit_nxt = '0;
            w_rpt_cnt_nxt = '0;
        end else if (w_rpt_fire) begin
            w_op_next     = r_rpt_bit;
            w_state_nxt   = RPT_REPEAT;
            w_rpt_cnt_nxt = '0;
        end else if (r_state == RPT_IDLE) begin
            w_rpt_cnt_nxt = '0;
        end
    end
`else
    always_comb begin
        w_op_next = busy ? '0 : w_press_win;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= '0;
        end else begin
            r_op <= w_op_next;
        end
    end

    assign operation = r_op;
    assign btn_level = w_level;

endmodule

// File: tb/tb_btn_op_gen.sv
// Directed bench for btn_op_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
// Edge 0 is the first rising edge that samples the new raw value; outputs are sampled 1ns after each edge.
module tb_btn_op_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [4:0] btn_raw;
    logic [4:0] operation;
    logic [4:0] btn_level;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_op_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .busy     (busy),
        .operation(operation),
        .btn_level(btn_level)
    );

    task automatic apply_reset();
        rst     = 1'b1;
        btn_raw = '0;
        busy    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        busy    = 1'b0;
        btn_raw = 5'b11111;
        #1;
        n_vec++;
        if (operation !== 5'b00000 || btn_level !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_async: operation=%b btn_level=%b required 00000/00000", operation, btn_level);
        end
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (operation !== 5'b00000 || btn_level !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_hold edge %0d: operation=%b btn_level=%b required 00000/00000", e, operation, btn_level);
            end
        end
    endtask

    task automatic test_single_press();
        logic [4:0] exp;
        apply_reset();
        btn_raw = 5'b00001;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            #1;
            exp = (e == 7) ? 5'b00001 : 5'b00000;
            n_vec++;
            if (operation !== exp) begin
                n_err++;
                $display("FAIL single_press edge %0d: operation=%b required %b", e, operation, exp);
            end
            if (e == 10) begin
                n_vec++;
                if (btn_level !== 5'b00001) begin
                    n_err++;
                    $display("FAIL single_level_high: btn_level=%b required 00001", btn_level);
                end
            end
            if (e == 14) btn_raw = 5'b00000;
        end
        n_vec++;
        if (btn_level !== 5'b00000) begin
            n_err++;
            $display("FAIL single_level_release: btn_level=%b required 00000", btn_level);
        end
    endtask

    function automatic logic [4:0] bounce_raw(input int e);
        if (e < 12)  return ((e / 2) % 2 == 0) ? 5'b00100 : 5'b00000;
        if (e <= 30) return 5'b00100;
        return 5'b00000;
    endfunction

    task automatic test_bounce();
        logic [4:0] exp;
        int         pulses;
        pulses = 0;
        apply_reset();
        btn_raw = bounce_raw(0);
        for (int e = 0; e < 46; e++) begin
            @(posedge clk);
            #1;
            exp = (e == 19) ? 5'b00100 : 5'b00000;
            if (operation !== 5'b00000) pulses++;
            n_vec++;
            if (operation !== exp) begin
                n_err++;
                $display("FAIL bounce edge %0d: operation=%b required %b", e, operation, exp);
            end
            btn_raw = bounce_raw(e + 1);
        end
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL bounce_count: pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp;
        apply_reset();
        btn_raw = 5'b10010;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            exp = (e == 7) ? 5'b00010 : 5'b00000;
            n_vec++;
            if (operation !== exp) begin
                n_err++;
                $display("FAIL simultaneous edge %0d: operation=%b required %b", e, operation, exp);
            end
            if (e == 14) btn_raw = 5'b00000;
        end
    endtask

    task automatic test_busy();
        apply_reset();
        btn_raw = 5'b00010;
        busy    = 1'b1;
        for (int e = 0; e < 31; e++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (operation !== 5'b00000) begin
                n_err++;
                $display("FAIL busy_drop edge %0d: operation=%b required 00000", e, operation);
            end
            if (e == 8) begin
                n_vec++;
                if (btn_level !== 5'b00010) begin
                    n_err++;
                    $display("FAIL busy_level: btn_level=%b required 00010", btn_level);
                end
            end
            if (e == 9)  busy = 1'b0;
            if (e == 20) btn_raw = 5'b00000;
        end
    endtask

    task automatic test_auto_repeat();
        logic [4:0] exp;
        logic       hit;
        apply_reset();
        btn_raw = 5'b10000;
        for (int e = 0; e < 66; e++) begin
            @(posedge clk);
            #1;
`ifdef BTN_AUTO_REPEAT_EN
            hit = (e == 7) || (e == 27) || (e == 35) || (e == 43) || (e == 51);
`else
            hit = (e == 7);
`endif
            exp = hit ? 5'b10000 : 5'b00000;
            n_vec++;
            if (operation !== exp) begin
                n_err++;
                $display("FAIL auto_repeat edge %0d: operation=%b required %b", e, operation, exp);
            end
            if (e == 49) btn_raw = 5'b00000;
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] exp;
        apply_reset();
        btn_raw = 5'b01000;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            exp = (e == 7) ? 5'b01000 : 5'b00000;
            n_vec++;
            if (operation !== exp) begin
                n_err++;
                $display("FAIL mid_hold_pre edge %0d: operation=%b required %b", e, operation, exp);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if (operation !== 5'b00000 || btn_level !== 5'b00000) begin
            n_err++;
            $display("FAIL mid_hold_async: operation=%b btn_level=%b required 00000/00000", operation, btn_level);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 21; e++) begin
            @(posedge clk);
            #1;
            exp = (e == 7) ? 5'b01000 : 5'b00000;
            n_vec++;
            if (operation !== exp) begin
                n_err++;
                $display("FAIL mid_hold_post edge %0d: operation=%b required %b", e, operation, exp);
            end
        end
        btn_raw = 5'b00000;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_busy();
        test_auto_repeat();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
